// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the writeback-port and MDU-result signals. The arbiter takes the slave side.
// The pipeline/MDU side takes the master side.
interface regfile_wport_arbiter_if;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic        MdValid;
   logic        MdReady;
   logic [4:0]  MdRd;
   logic [31:0] MdResult;
   logic        RfWE;
   logic [4:0]  RfA3;
   logic [31:0] RfWD;
   logic        StallReq;
   logic [1:0]  PendCnt;

   modport master (
      output RegWriteW, RdW, ResultW, MdValid, MdRd, MdResult,
      input  MdReady, RfWE, RfA3, RfWD, StallReq, PendCnt
   );

   modport slave (
      input  RegWriteW, RdW, ResultW, MdValid, MdRd, MdResult,
      output MdReady, RfWE, RfA3, RfWD, StallReq, PendCnt
   );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the single register-file write port between the pipeline writeback stage and the MDU.
// The pipeline always wins; MDU results wait in a 2-deep FIFO, and a starving result raises StallReq.
module regfile_wport_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   regfile_wport_arbiter_if.slave rf
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [1:0]  cnt_q, cnt_d;
   logic        head_q, head_d;
   logic        tail_q, tail_d;
   logic [3:0]  wait_q, wait_d;
   logic [4:0]  rd_q   [2];
   logic [31:0] data_q [2];

   logic live, empty, accept, pass, push, pop;

   always_comb begin
      live   = rf.RegWriteW && (rf.RdW != 5'd0);
      empty  = (cnt_q == 2'd0);
      accept = rf.MdValid && (cnt_q < 2'd2);
      pass   = !live && empty && accept && (rf.MdRd != 5'd0);
      pop    = !live && !empty;
      // An accepted result aimed at x0 is consumed here and never enters the FIFO.
      push   = accept && (rf.MdRd != 5'd0) && !pass;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      head_d = head_q ^ pop;
      tail_d = tail_q ^ push;
      wait_d = wait_q;
      if (empty || pop)
         wait_d = 4'd0;
      else if (wait_q < STARVE_LIM)
         wait_d = wait_q + 4'd1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         head_q <= 1'b0;
         tail_q <= 1'b0;
         wait_q <= 4'd0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         wait_q <= wait_d;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; the count alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[tail_q]   <= rf.MdRd;
         data_q[tail_q] <= rf.MdResult;
      end
   end

   always_comb begin
      rf.RfWE = 1'b0;
      rf.RfA3 = 5'd0;
      rf.RfWD = 32'd0;
      if (live) begin
         rf.RfWE = 1'b1;
         rf.RfA3 = rf.RdW;
         rf.RfWD = rf.ResultW;
      end else if (!empty) begin
         rf.RfWE = 1'b1;
         rf.RfA3 = rd_q[head_q];
         rf.RfWD = data_q[head_q];
      end else if (pass) begin
         rf.RfWE = 1'b1;
         rf.RfA3 = rf.MdRd;
         rf.RfWD = rf.MdResult;
      end
   end

   assign rf.MdReady  = (cnt_q < 2'd2);
   assign rf.StallReq = (wait_q == STARVE_LIM);
   assign rf.PendCnt  = cnt_q;

endmodule

// File: doc/regfile_wport_arbiter.md
REGFILE_WPORT_ARBITER -- requirements
Module: regfile_wport_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_MAX, default 4, the number of cycles a buffered result may wait before the block forces a pipeline stall (legal range 1-15).
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL provide port RegWriteW, input, 1 bit: writeback-stage write enable.
REQ-005 The block SHALL provide port RdW, input, 5 bits: writeback-stage destination register.
REQ-006 The block SHALL provide port ResultW, input, 32 bits: writeback-stage result, already selected.
REQ-007 The block SHALL provide port MdValid, input, 1 bit: multi-cycle unit (MUL/DIV) result valid.
REQ-008 The block SHALL provide port MdReady, output, 1 bit: the block can accept an MDU result this cycle.
REQ-009 The block SHALL provide port MdRd, input, 5 bits: MDU destination register.
REQ-010 The block SHALL provide port MdResult, input, 32 bits: MDU result.
REQ-011 The block SHALL provide port RfWE, output, 1 bit: register-file write enable.
REQ-012 The block SHALL provide port RfA3, output, 5 bits: register-file write address.
REQ-013 The block SHALL provide port RfWD, output, 32 bits: register-file write data.
REQ-014 The block SHALL provide port StallReq, output, 1 bit: request to the hazard unit to bubble writeback.
REQ-015 The block SHALL provide port PendCnt, output, 2 bits: number of buffered MDU results (0-2).

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {Rd[4:0], data[31:0]} for MDU results, with a registered count and head/tail pointers that wrap modulo 2.
REQ-017 A pipeline write SHALL be "live" only when RegWriteW=1 and RdW!=0.
REQ-018 Pipeline priority: when a pipeline write is live, the block SHALL drive RfWE=1, RfA3=RdW and RfWD=ResultW in the same cycle (combinational, zero latency), regardless of FIFO state or StallReq.
REQ-019 Drain: when no pipeline write is live and the FIFO is non-empty, the block SHALL drive RfWE=1 with RfA3/RfWD set to the FIFO head, and SHALL pop the head at the clock edge.
REQ-020 Pass-through: when no pipeline write is live, the FIFO is empty and MdValid=1 with MdRd!=0, the block SHALL write MdRd/MdResult directly in the same cycle without buffering.
REQ-021 Idle output: when none of REQ-018 to REQ-020 applies, the block SHALL drive RfWE=0, RfA3=0 and RfWD=0.
REQ-022 MdReady SHALL be 1 exactly when the registered count is less than 2, independent of MdValid; the block SHALL NOT accept a new result at count 2 even when the head drains in that cycle.
REQ-023 Acceptance: an MDU result SHALL be accepted when MdValid=1 and MdReady=1, and SHALL then be either passed through (REQ-020) or pushed to the tail at the clock edge.
REQ-024 Ordering: MDU results SHALL reach the register file in acceptance order; pass-through SHALL be used only when the FIFO is empty.
REQ-025 x0 results: an accepted MDU result with MdRd=0 SHALL be consumed and discarded; it SHALL NOT be pushed and SHALL never assert RfWE.
REQ-026 Simultaneous push and pop at count 1 SHALL leave the count at 1 and advance both pointers.
REQ-027 Starvation counter WaitCnt (4 bits): SHALL clear to 0 when the FIFO is empty or the head drains; otherwise SHALL increment each cycle, saturating at STARVE_MAX.
REQ-028 StallReq SHALL equal (WaitCnt==STARVE_MAX), decoded from the registered value; it SHALL deassert on the cycle after the head drains, unless the new head is already at the limit.
REQ-029 While StallReq=1, the hazard unit is responsible for the bubble; if RegWriteW is nonetheless live, REQ-018 SHALL still apply and WaitCnt SHALL stay saturated.
REQ-030 PendCnt SHALL equal the registered FIFO count.

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL set count, pointers and WaitCnt to 0; reset SHALL override any simultaneous push, pop or acceptance, and buffered results SHALL be lost.
REQ-032 After reset the outputs SHALL be MdReady=1, StallReq=0 and PendCnt=0, and RfWE/RfA3/RfWD SHALL follow REQ-018 to REQ-021 from the inputs alone.

Verification
REQ-033 Pass-through: FIFO empty, RegWriteW=0, MdValid=1, MdRd=5, MdResult=0x1234 -> RfWE=1, RfA3=5, RfWD=0x1234 in the same cycle; PendCnt stays 0.
REQ-034 Conflict: RegWriteW=1, RdW=3, ResultW=0xA, plus MdValid=1, MdRd=7, MdResult=0xB -> port writes x3=0xA; PendCnt=1; next cycle with RegWriteW=0 -> writes x7=0xB and PendCnt=0.
REQ-035 Full: RegWriteW=1 (RdW!=0) held, two MDU results accepted -> PendCnt=2 and MdReady=0; a third MdValid is not accepted; results later drain in acceptance order.
REQ-036 Starvation: STARVE_MAX=4, one buffered result, RegWriteW=1 every cycle -> StallReq=1 on the 5th cycle after the push; first RegWriteW=0 cycle drains the result; StallReq=0 the next cycle.
REQ-037 Boundaries: RegWriteW=1 with RdW=0 and FIFO count 1 -> head drains; accepted MdRd=0 -> RfWE=0 and PendCnt unchanged; rst_n=0 with PendCnt=2 -> PendCnt=0, MdReady=1, StallReq=0 after the edge.
